alu_multicycle_unit: RTL and testbench

Parametrised multi-cycle arithmetic unit. Sits beside the 1-cycle ALU in the execute stage and handles the iterative operations: multiply, divide, remainder, and logical/arithmetic shifts. Operands enter through a valid/ready handshake, and results leave through a valid/ready handshake that holds under backpressure. Replaces edge-triggered enable/idle signalling with fully synchronous handshakes and adds division.

---
 rtl/alu_multicycle_unit.sv | 203 ++++++++++++++++++++
 tb/tb_alu_multicycle_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_multicycle_unit.sv
// rtl/alu_multicycle_unit.sv - iterative MUL/DIVU/REMU/shift unit with valid/ready handshakes
// Optional feature macro: ALU_OVF_FLAG_EN (adds ovf_flag output).
module alu_multicycle_unit #(
   parameter int DATA_WIDTH   = 64,
   parameter int OPCODE_WIDTH = 3,
   parameter int SHAMT_WIDTH  = $clog2(DATA_WIDTH),
   parameter int CNT_WIDTH    = $clog2(DATA_WIDTH) + 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [OPCODE_WIDTH-1:0] op_code,
   input  logic [DATA_WIDTH-1:0]   operand_1,
   input  logic [DATA_WIDTH-1:0]   operand_2,
   input  logic                    flush,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [DATA_WIDTH-1:0]   result,
   output logic                    div_zero,
   output logic                    invalid_op,
`ifdef ALU_OVF_FLAG_EN
   output logic                    ovf_flag,
`endif
   output logic                    busy
);

   localparam logic [OPCODE_WIDTH-1:0] OP_MUL  = OPCODE_WIDTH'(0);
   localparam logic [OPCODE_WIDTH-1:0] OP_DIVU = OPCODE_WIDTH'(1);
   localparam logic [OPCODE_WIDTH-1:0] OP_REMU = OPCODE_WIDTH'(2);
   localparam logic [OPCODE_WIDTH-1:0] OP_SLL  = OPCODE_WIDTH'(3);
   localparam logic [OPCODE_WIDTH-1:0] OP_SRL  = OPCODE_WIDTH'(4);
   localparam logic [OPCODE_WIDTH-1:0] OP_SRA  = OPCODE_WIDTH'(5);

`ifdef ALU_OVF_FLAG_EN
   localparam int ACC_W = 2 * DATA_WIDTH;
`else
   localparam int ACC_W = DATA_WIDTH;
`endif

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [OPCODE_WIDTH-1:0] op_q;
   logic [DATA_WIDTH-1:0]   opa_q, opb_q, rem_q, result_q;
   logic [ACC_W-1:0]        acc_q, mcand_q;
   logic [CNT_WIDTH-1:0]    cnt_q, n_req;
   logic                    div_zero_q, invalid_q;
   logic                    accept;
   logic [DATA_WIDTH-1:0]   imm_result, opa_nx, opb_nx, rem_nx, step_result, trial_lo;
   logic [ACC_W-1:0]        acc_nx, mcand_nx;
   logic                    trial_ge;
`ifdef ALU_OVF_FLAG_EN
   logic                    ovf_q, ovf_nx;
   assign ovf_flag = ovf_q;
`endif

   assign in_ready   = (state_q == S_IDLE) && !flush;
   assign accept     = in_valid && in_ready;
   assign out_valid  = (state_q == S_DONE);
   assign busy       = (state_q != S_IDLE);
   assign result     = result_q;
   assign div_zero   = div_zero_q;
   assign invalid_op = invalid_q;

   // Iteration count and the result used when no iterations are needed.
   always_comb begin
      n_req      = '0;
      imm_result = '0;
      case (op_code)
         OP_MUL:  n_req = CNT_WIDTH'(DATA_WIDTH);
         OP_DIVU: if (operand_2 == '0) imm_result = '1;
                  else n_req = CNT_WIDTH'(DATA_WIDTH);
         OP_REMU: if (operand_2 == '0) imm_result = operand_1;
                  else n_req = CNT_WIDTH'(DATA_WIDTH);
         OP_SLL, OP_SRL, OP_SRA: begin
            n_req      = CNT_WIDTH'(operand_2[SHAMT_WIDTH-1:0]);
            imm_result = operand_1;
         end
         default: ;
      endcase
   end

   // One iteration. Division shifts the dividend out of opa_q MSB-first while quotient bits
   // enter at the LSB; the partial remainder is always below the divisor, so W bits suffice.
   always_comb begin
      acc_nx      = acc_q;
      mcand_nx    = mcand_q;
      opa_nx      = opa_q;
      opb_nx      = opb_q;
      rem_nx      = rem_q;
      step_result = '0;
      trial_lo    = {rem_q[DATA_WIDTH-2:0], opa_q[DATA_WIDTH-1]};
      trial_ge    = rem_q[DATA_WIDTH-1] || (trial_lo >= opb_q);
`ifdef ALU_OVF_FLAG_EN
      ovf_nx      = ovf_q;
`endif
      case (op_q)
         OP_MUL: begin
            if (opb_q[0]) acc_nx = acc_q + mcand_q;
            mcand_nx    = mcand_q << 1;
            opb_nx      = opb_q >> 1;
            step_result = acc_nx[DATA_WIDTH-1:0];
`ifdef ALU_OVF_FLAG_EN
            ovf_nx      = |acc_nx[ACC_W-1:DATA_WIDTH];
`endif
         end
         OP_DIVU, OP_REMU: begin
            opa_nx      = {opa_q[DATA_WIDTH-2:0], trial_ge};
            rem_nx      = trial_ge ? (trial_lo - opb_q) : trial_lo;
            step_result = (op_q == OP_DIVU) ? opa_nx : rem_nx;
         end
         OP_SLL: begin
            opa_nx      = opa_q << 1;
            step_result = opa_nx;
`ifdef ALU_OVF_FLAG_EN
            ovf_nx      = ovf_q | opa_q[DATA_WIDTH-1];
`endif
         end
         OP_SRL: begin
            opa_nx      = opa_q >> 1;
            step_result = opa_nx;
         end
         OP_SRA: begin
            opa_nx      = {opa_q[DATA_WIDTH-1], opa_q[DATA_WIDTH-1:1]};
            step_result = opa_nx;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (accept) state_d = (n_req == '0) ? S_DONE : S_BUSY;
         S_BUSY:  if (cnt_q == CNT_WIDTH'(1)) state_d = S_DONE;
         S_DONE:  if (out_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (flush) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         op_q       <= '0;
         opa_q      <= '0;
         opb_q      <= '0;
         rem_q      <= '0;
         acc_q      <= '0;
         mcand_q    <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         div_zero_q <= 1'b0;
         invalid_q  <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
         ovf_q      <= 1'b0;
`endif
      end else if (flush) begin
         div_zero_q <= 1'b0;
         invalid_q  <= 1'b0;
`ifdef ALU_OVF_FLAG_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: if (accept) begin
               op_q       <= op_code;
               opa_q      <= operand_1;
               opb_q      <= operand_2;
               rem_q      <= '0;
               acc_q      <= '0;
               mcand_q    <= ACC_W'(operand_1);
               cnt_q      <= n_req;
               div_zero_q <= ((op_code == OP_DIVU) || (op_code == OP_REMU)) && (operand_2 == '0);
               invalid_q  <= (op_code > OP_SRA);
`ifdef ALU_OVF_FLAG_EN
               ovf_q      <= 1'b0;
`endif
               if (n_req == '0) result_q <= imm_result;
            end
            S_BUSY: begin
               cnt_q   <= cnt_q - CNT_WIDTH'(1);
               opa_q   <= opa_nx;
               opb_q   <= opb_nx;
               rem_q   <= rem_nx;
               acc_q   <= acc_nx;
               mcand_q <= mcand_nx;
`ifdef ALU_OVF_FLAG_EN
               ovf_q   <= ovf_nx;
`endif
               if (cnt_q == CNT_WIDTH'(1)) result_q <= step_result;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_multicycle_unit.sv
// tb/tb_alu_multicycle_unit.sv - scoreboard bench for alu_multicycle_unit at DATA_WIDTH = 8
module tb_alu_multicycle_unit;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         flush = 1'b0;
   logic         out_ready = 1'b0;
   logic [2:0]   op_code = '0;
   logic [W-1:0] operand_1 = '0;
   logic [W-1:0] operand_2 = '0;
   logic         in_ready, out_valid, div_zero, invalid_op, busy;
   logic [W-1:0] result;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int ordy_mode = 1;

   typedef struct {
      logic [W-1:0] res;
      logic         dz;
      logic         inv;
      int           due;
   } exp_t;
   exp_t sb[$];

   alu_multicycle_unit #(.DATA_WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_code(op_code), .operand_1(operand_1), .operand_2(operand_2), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .result(result),
      .div_zero(div_zero), .invalid_op(invalid_op), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W-1:0] r, output logic dz, output logic inv,
                                 output int n);
      logic signed [W-1:0] sa;
      int s;
      sa = a;
      s = int'(b[2:0]);
      r = '0; dz = 1'b0; inv = 1'b0; n = W;
      case (op)
         3'd0: r = a * b;
         3'd1: if (b == 0) begin r = '1; dz = 1'b1; n = 0; end else r = a / b;
         3'd2: if (b == 0) begin r = a; dz = 1'b1; n = 0; end else r = a % b;
         3'd3: begin r = a << s; n = s; end
         3'd4: begin r = a >> s; n = s; end
         3'd5: begin r = sa >>> s; n = s; end
         default: begin inv = 1'b1; n = 0; end
      endcase
   endfunction

   initial forever begin
      @(posedge clk); #1;
      case (ordy_mode)
         0:       out_ready = 1'b0;
         1:       out_ready = 1'b1;
         default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
   end

   // Monitor: latency on out_valid rise, hold-stability under backpressure, pop on handshake
   initial begin
      logic         prev_ov, prev_ordy;
      logic [W-1:0] held;
      exp_t         e;
      prev_ov = 1'b0; prev_ordy = 1'b0; held = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ov = 1'b0;
         end else begin
            if (busy) check("in_ready_while_busy", in_ready, 0);
            if (out_valid && !prev_ov) begin
               check("output_expected", sb.size() != 0, 1);
               if (sb.size() != 0) check("latency", cyc, sb[0].due);
            end
            if (out_valid && prev_ov && !prev_ordy) check("hold_result", result, held);
            if (out_valid && out_ready && sb.size() != 0) begin
               e = sb.pop_front();
               check("result", result, e.res);
               check("div_zero", div_zero, e.dz);
               check("invalid_op", invalid_op, e.inv);
            end
            prev_ov = out_valid;
            prev_ordy = out_ready;
            held = result;
         end
      end
   end

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit expect_out);
      exp_t e;
      int n;
      int guard;
      guard = 0;
      @(posedge clk); #1;
      in_valid = 1'b1; op_code = op; operand_1 = a; operand_2 = b;
      @(negedge clk);
      while (!in_ready && guard < 500) begin
         @(negedge clk);
         guard++;
      end
      check("accept_timeout", guard < 500, 1);
      model(op, a, b, e.res, e.dz, e.inv, n);
      e.due = cyc + 1 + n;
      if (expect_out) sb.push_back(e);
      @(posedge clk); #1;
      in_valid = 1'b0;
      op_code = 3'($urandom);
      operand_1 = W'($urandom);
      operand_2 = W'($urandom);
   endtask

   task automatic wait_done();
      int g;
      g = 0;
      while ((sb.size() != 0 || busy) && g < 2000) begin
         @(negedge clk);
         g++;
      end
      check("drain_timeout", g < 2000, 1);
   endtask

   initial begin
      logic [2:0]   op;
      logic [W-1:0] a, b;
      int           g;

      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_result", result, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_div_zero", div_zero, 0);
      check("rst_invalid_op", invalid_op, 0);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;

      issue(3'd0, 8'd13, 8'd11, 1'b1);
      wait_done();
      issue(3'd1, 8'd100, 8'd7, 1'b1);
      issue(3'd2, 8'd100, 8'd7, 1'b1);
      wait_done();
      issue(3'd1, 8'h5A, 8'h00, 1'b1);
      issue(3'd2, 8'h5A, 8'h00, 1'b1);
      issue(3'd5, 8'h80, 8'd3, 1'b1);
      issue(3'd3, 8'h01, 8'd0, 1'b1);
      issue(3'd7, 8'h33, 8'h44, 1'b1);
      issue(3'd3, 8'hC3, 8'hF9, 1'b1);
      wait_done();

      ordy_mode = 0;
      repeat (2) @(posedge clk);
      issue(3'd0, 8'd3, 8'd5, 1'b1);
      g = 0;
      while (!out_valid && g < 100) begin
         @(negedge clk);
         g++;
      end
      check("bp_valid_timeout", g < 100, 1);
      repeat (4) @(negedge clk);
      check("bp_still_valid", out_valid, 1);
      ordy_mode = 1;
      g = 0;
      while (!out_ready && g < 10) begin
         @(negedge clk);
         g++;
      end
      @(negedge clk);
      check("bp_idle_after_ready", busy, 0);
      wait_done();

      issue(3'd0, 8'hB7, 8'h9D, 1'b0);
      repeat (3) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      check("flush_busy", busy, 0);
      check("flush_out_valid", out_valid, 0);
      check("flush_in_ready", in_ready, 1);

      issue(3'd1, 8'hE4, 8'h0B, 1'b0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_out_valid", out_valid, 0);
      check("rst_mid_result", result, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_mid_in_ready", in_ready, 1);

      issue(3'd4, 8'hF0, 8'd4, 1'b1);
      wait_done();

      ordy_mode = 2;
      repeat (60) begin
         op = 3'($urandom_range(0, 7));
         a = W'($urandom);
         b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
         issue(op, a, b, 1'b1);
      end
      wait_done();
      ordy_mode = 1;
      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb.size(), 0);

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
